tmr_voter: RTL

- Consumes the three result/carry outputs of the triplex ALU32 lanes and produces one registered, majority-voted result.
- Detects per-lane disagreement and keeps saturating per-lane error counts.
- Runs a per-lane health state machine that retires a persistently wrong lane and continues in degraded (duplex or simplex) mode.
- Sits directly downstream of the three ALU32 instances, in place of the ad-hoc result comparison.

---
 rtl/tmr_pkg.sv | 17 +
 rtl/tmr_lane_health.sv | 91 +++++++++
 rtl/tmr_voter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the triple-modular-redundancy voter.
package tmr_pkg;

    localparam int N_LANES = 3;

    typedef enum logic [1:0] {
        LANE_OK      = 2'd0,
        LANE_SUSPECT = 2'd1,
        LANE_FAULTED = 2'd2
    } lane_state_t;

    // Single-bit two-out-of-three majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_lane_health.sv
// Per-lane health tracker: OK/SUSPECT/FAULTED state with a mismatch streak,
// plus a saturating mismatch counter. The parent arbitrates entry into
// FAULTED through i_grant so that only one lane retires per cycle.
module tmr_lane_health
    import tmr_pkg::*;
#(
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_mismatch,
    input  logic             i_clr_faults,
    input  logic             i_clr_counts,
    input  logic             i_grant,
    output logic             o_fault_req,
    output lane_state_t      o_state,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [8:0] THRESH9   = 9'(FAULT_THRESH);
    localparam logic [7:0] THRESH8   = 8'(FAULT_THRESH);
    localparam logic [7:0] THRESH_M1 = 8'(FAULT_THRESH - 1);

    lane_state_t      r_state;
    lane_state_t      w_state_nxt;
    logic [7:0]       r_streak;
    logic [7:0]       w_streak_nxt;
    logic [8:0]       w_streak_inc;
    logic             w_fault_req;
    logic [CNT_W-1:0] r_cnt;

    // OK always carries streak 0, so one increment covers both OK and SUSPECT.
    assign w_streak_inc = {1'b0, r_streak} + 9'd1;
    assign w_fault_req  = i_valid & i_mismatch & (r_state != LANE_FAULTED)
                        & (w_streak_inc >= THRESH9);

    // State and streak registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LANE_OK;
            r_streak <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Next-state logic; a lane denied the grant parks one step short of the threshold.
    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        if (i_clr_faults) begin
            w_state_nxt  = LANE_OK;
            w_streak_nxt = 8'd0;
        end else if (i_valid && (r_state != LANE_FAULTED)) begin
            if (i_mismatch) begin
                if (w_fault_req) begin
                    if (i_grant) begin
                        w_state_nxt  = LANE_FAULTED;
                        w_streak_nxt = THRESH8;
                    end else begin
                        w_state_nxt  = LANE_SUSPECT;
                        w_streak_nxt = THRESH_M1;
                    end
                end else begin
                    w_state_nxt  = LANE_SUSPECT;
                    w_streak_nxt = w_streak_inc[7:0];
                end
            end else begin
                w_state_nxt  = LANE_OK;
                w_streak_nxt = 8'd0;
            end
        end
    end

    // Saturating mismatch counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || i_clr_counts) begin
            r_cnt <= '0;
        end else if (i_valid && i_mismatch && (r_state != LANE_FAULTED) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_fault_req = w_fault_req;
    assign o_state     = r_state;
    assign o_err_cnt   = r_cnt;

endmodule

// File: rtl/tmr_voter.sv
// Majority voter for three ALU lanes with per-lane health tracking.
// Handshake: a word presented with in_valid=1 on a rising edge appears on
// result/carry_out with out_valid=1 exactly one edge later; there is no
// backpressure. While out_valid=0 the data outputs hold and the error flags
// are low.
module tmr_voter
    import tmr_pkg::*;
#(
    parameter int W            = 32,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     r0,
    input  logic [W-1:0]     r1,
    input  logic [W-1:0]     r2,
    input  logic             c0,
    input  logic             c1,
    input  logic             c2,
    input  logic             clr_counts,
    input  logic             clr_faults,
    output logic             out_valid,
    output logic [W-1:0]     result,
    output logic             carry_out,
    output logic             err_detect,
    output logic             err_uncorr,
    output logic [2:0]       lane_fault,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2
);

    localparam int VW = W + 1;

    logic [VW-1:0]      w_word [N_LANES];
    lane_state_t        w_state [N_LANES];
    logic [CNT_W-1:0]   w_cnt [N_LANES];
    logic [N_LANES-1:0] w_healthy;
    logic [N_LANES-1:0] w_mismatch;
    logic [N_LANES-1:0] w_req;
    logic [N_LANES-1:0] w_grant;
    logic               w_multi;
    logic [VW-1:0]      w_vote;
    logic               w_uncorr;

    logic               r_out_valid;
    logic [VW-1:0]      r_word;
    logic               r_err_detect;
    logic               r_err_uncorr;

    assign w_word[0] = {c0, r0};
    assign w_word[1] = {c1, r1};
    assign w_word[2] = {c2, r2};

    // Mismatches only mean something when at least two lanes are still trusted.
    assign w_multi = maj3(w_healthy[0], w_healthy[1], w_healthy[2]);

    // Pick the output word according to which lanes are still healthy.
    always_comb begin
        w_vote   = '0;
        w_uncorr = 1'b0;
        case (w_healthy)
            3'b111: begin
                for (int b = 0; b < VW; b++) begin
                    w_vote[b] = maj3(w_word[0][b], w_word[1][b], w_word[2][b]);
                end
                w_uncorr = (w_word[0] != w_word[1]) && (w_word[0] != w_word[2])
                        && (w_word[1] != w_word[2]);
            end
            3'b011: begin
                w_vote   = w_word[0];
                w_uncorr = (w_word[0] != w_word[1]);
            end
            3'b101: begin
                w_vote   = w_word[0];
                w_uncorr = (w_word[0] != w_word[2]);
            end
            3'b110: begin
                w_vote   = w_word[1];
                w_uncorr = (w_word[1] != w_word[2]);
            end
            3'b010: begin
                w_vote   = w_word[1];
                w_uncorr = 1'b1;
            end
            3'b100: begin
                w_vote   = w_word[2];
                w_uncorr = 1'b1;
            end
            default: begin
                w_vote   = w_word[0];
                w_uncorr = 1'b1;
            end
        endcase
    end

    // Per-lane disagreement with the chosen word.
    always_comb begin
        w_mismatch = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_mismatch[k] = in_valid & w_healthy[k] & w_multi & (w_word[k] != w_vote);
        end
    end

    // Lowest-index lane wins when several hit the threshold together.
    assign w_grant[0] = w_req[0];
    assign w_grant[1] = w_req[1] & ~w_req[0];
    assign w_grant[2] = w_req[2] & ~w_req[0] & ~w_req[1];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        tmr_lane_health #(
            .FAULT_THRESH (FAULT_THRESH),
            .CNT_W        (CNT_W)
        ) u_health (
            .clk          (clk),
            .rst          (rst),
            .i_valid      (in_valid),
            .i_mismatch   (w_mismatch[g]),
            .i_clr_faults (clr_faults),
            .i_clr_counts (clr_counts),
            .i_grant      (w_grant[g]),
            .o_fault_req  (w_req[g]),
            .o_state      (w_state[g]),
            .o_err_cnt    (w_cnt[g])
        );
        assign w_healthy[g] = (w_state[g] != LANE_FAULTED);
    end

    // Output register stage; data holds across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_word       <= '0;
            r_err_detect <= 1'b0;
            r_err_uncorr <= 1'b0;
        end else begin
            r_out_valid  <= in_valid;
            if (in_valid) begin
                r_word <= w_vote;
            end
            r_err_detect <= |w_mismatch;
            r_err_uncorr <= in_valid & w_uncorr;
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_word[W-1:0];
    assign carry_out  = r_word[W];
    assign err_detect = r_err_detect;
    assign err_uncorr = r_err_uncorr;
    assign lane_fault = ~w_healthy;
    assign err_cnt0   = w_cnt[0];
    assign err_cnt1   = w_cnt[1];
    assign err_cnt2   = w_cnt[2];

endmodule
